// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline constants and the decoded-operand record used by the
// hazard unit and the replay queue.
package hazard_stall_unit_pkg;
   localparam int NREGS     = 16;
   localparam int REG_W     = 4;
   localparam int CNT_W     = 2;
   localparam int LOAD_LAT  = 2;
   localparam int ALU_LAT   = 0;
   localparam int MAX_STALL = 2;

   typedef logic [REG_W-1:0] reg_idx_t;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      reg_idx_t src_a;
      logic     src_a_used;
      reg_idx_t src_b;
      logic     src_b_used;
      reg_idx_t dest;
      logic     writes;
      logic     is_load;
   } dec_op_t;
endpackage

// File: rtl/hazard_stall_unit_scoreboard.sv
// Per-register countdown of cycles until an in-flight result is forwardable,
// with two busy read ports and a single-register squash clear.
module hazard_scoreboard
   import hazard_stall_unit_pkg::*;
#(
   parameter int LOAD_LAT = hazard_stall_unit_pkg::LOAD_LAT,
   parameter int ALU_LAT  = hazard_stall_unit_pkg::ALU_LAT
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     set_en,
   input  reg_idx_t set_idx,
   input  logic     set_load,
   input  logic     clr_en,
   input  reg_idx_t clr_idx,
   input  reg_idx_t rd_a_idx,
   input  reg_idx_t rd_b_idx,
   output logic     busy_a,
   output logic     busy_b
);
   localparam cnt_t LOAD_VAL = cnt_t'(LOAD_LAT);
   localparam cnt_t ALU_VAL  = cnt_t'(ALU_LAT);

   logic [NREGS-1:0][CNT_W-1:0] cnt;

   // r0 is hardwired untracked; a new issue wins over both clear and decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt[0] <= '0;
         for (int r = 1; r < NREGS; r++) begin
            if (set_en && set_idx == reg_idx_t'(r))
               cnt[r] <= set_load ? LOAD_VAL : ALU_VAL;
            else if (clr_en && clr_idx == reg_idx_t'(r))
               cnt[r] <= '0;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - 1'b1;
         end
      end
   end

   assign busy_a = (rd_a_idx != '0) && (cnt[rd_a_idx] != '0);
   assign busy_b = (rd_b_idx != '0) && (cnt[rd_b_idx] != '0);
endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for decode: combines scoreboard hazards with branch
// mispredicts and polices the replay queue's stall-run limit.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int LOAD_LAT  = hazard_stall_unit_pkg::LOAD_LAT,
   parameter int ALU_LAT   = hazard_stall_unit_pkg::ALU_LAT,
   parameter int MAX_STALL = hazard_stall_unit_pkg::MAX_STALL
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dec_valid,
   input  logic [3:0] dec_src_a,
   input  logic       dec_src_a_used,
   input  logic [3:0] dec_src_b,
   input  logic       dec_src_b_used,
   input  logic [3:0] dec_dest,
   input  logic       dec_writes,
   input  logic       dec_is_load,
   input  logic       br_mispredict,
   output logic       stall,
   output logic       flush,
   output logic [1:0] stall_run,
   output logic       overrun
);
   localparam logic [1:0] RUN_LIMIT = 2'(MAX_STALL);

   dec_op_t  op;
   logic     busy_a, busy_b, issue;
   logic     last_valid;
   reg_idx_t last_dest;

   assign op = '{src_a: dec_src_a, src_a_used: dec_src_a_used,
                 src_b: dec_src_b, src_b_used: dec_src_b_used,
                 dest: dec_dest, writes: dec_writes, is_load: dec_is_load};

   // Gated by rst_n so both outputs are quiet while reset is asserted.
   assign flush = rst_n & br_mispredict;
   assign stall = rst_n & dec_valid & ~br_mispredict &
                  ((op.src_a_used & busy_a) | (op.src_b_used & busy_b));
   assign issue = dec_valid & ~stall & ~flush;

   hazard_scoreboard #(.LOAD_LAT(LOAD_LAT), .ALU_LAT(ALU_LAT)) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue & op.writes),
      .set_idx  (op.dest),
      .set_load (op.is_load),
      .clr_en   (flush & last_valid),
      .clr_idx  (last_dest),
      .rd_a_idx (op.src_a),
      .rd_b_idx (op.src_b),
      .busy_a   (busy_a),
      .busy_b   (busy_b)
   );

   // Only a writing instruction can leave a counter behind for the squash.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_valid <= 1'b0;
         last_dest  <= '0;
      end else begin
         last_valid <= issue & op.writes;
         last_dest  <= op.dest;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_run <= '0;
         overrun   <= 1'b0;
      end else begin
         if (flush || !stall)
            stall_run <= '0;
         else if (stall_run != 2'd3)
            stall_run <= stall_run + 2'd1;
         if (stall && stall_run == RUN_LIMIT)
            overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: a cycle table pushed through an expectation
// queue, plus directed overrun and reset-mid-stall sequences.
module tb_hazard_stall_unit;
   typedef struct {
      logic       v;
      logic [3:0] sa;
      logic       ua;
      logic [3:0] sb;
      logic       ub;
      logic [3:0] dst;
      logic       wr;
      logic       ld;
      logic       br;
      logic       es;
      logic       ef;
      logic [1:0] er;
      logic       eo;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dec_valid = 1'b0, dec_src_a_used = 1'b0, dec_src_b_used = 1'b0;
   logic       dec_writes = 1'b0, dec_is_load = 1'b0, br_mispredict = 1'b0;
   logic [3:0] dec_src_a = '0, dec_src_b = '0, dec_dest = '0;
   logic       stall, flush, overrun, stall3, flush3, overrun3;
   logic [1:0] stall_run, stall_run3;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   hazard_stall_unit dut (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
      .dec_src_a(dec_src_a), .dec_src_a_used(dec_src_a_used),
      .dec_src_b(dec_src_b), .dec_src_b_used(dec_src_b_used),
      .dec_dest(dec_dest), .dec_writes(dec_writes), .dec_is_load(dec_is_load),
      .br_mispredict(br_mispredict), .stall(stall), .flush(flush),
      .stall_run(stall_run), .overrun(overrun));

   hazard_stall_unit #(.LOAD_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
      .dec_src_a(dec_src_a), .dec_src_a_used(dec_src_a_used),
      .dec_src_b(dec_src_b), .dec_src_b_used(dec_src_b_used),
      .dec_dest(dec_dest), .dec_writes(dec_writes), .dec_is_load(dec_is_load),
      .br_mispredict(br_mispredict), .stall(stall3), .flush(flush3),
      .stall_run(stall_run3), .overrun(overrun3));

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [3:0] sa, input logic ua,
                               input logic [3:0] sb, input logic ub, input logic [3:0] dst,
                               input logic wr, input logic ld, input logic br,
                               input logic es, input logic ef, input logic [1:0] er,
                               input logic eo);
      vec_t r;
      r = '{v, sa, ua, sb, ub, dst, wr, ld, br, es, ef, er, eo};
      return r;
   endfunction

   task automatic drive(input vec_t r);
      dec_valid = r.v; dec_src_a = r.sa; dec_src_a_used = r.ua;
      dec_src_b = r.sb; dec_src_b_used = r.ub; dec_dest = r.dst;
      dec_writes = r.wr; dec_is_load = r.ld; br_mispredict = r.br;
   endtask

   task automatic idle();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   // Scoreboard consumer: one expectation per driven cycle, checked mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         vec_t e;
         e = exp_q.pop_front();
         chk("tbl_stall", int'(stall), int'(e.es));
         chk("tbl_flush", int'(flush), int'(e.ef));
         chk("tbl_run", int'(stall_run), int'(e.er));
         chk("tbl_overrun", int'(overrun), int'(e.eo));
      end
   end

   initial begin
      //           v  sa ua sb ub dst wr ld br | st fl run ov
      tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0,  0, 0, 0, 0)); // load r3
      tbl.push_back(mk(1, 3, 1, 0, 0, 6, 1, 0, 0,  1, 0, 0, 0)); // back-to-back use
      tbl.push_back(mk(1, 3, 1, 0, 0, 6, 1, 0, 0,  1, 0, 1, 0));
      tbl.push_back(mk(1, 3, 1, 0, 0, 6, 1, 0, 0,  0, 0, 2, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0,  0, 0, 0, 0)); // load r3
      tbl.push_back(mk(1, 1, 1, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0)); // independent
      tbl.push_back(mk(1, 0, 0, 3, 1, 8, 1, 0, 0,  1, 0, 0, 0)); // use via src b
      tbl.push_back(mk(1, 0, 0, 3, 1, 8, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0)); // alu r5
      tbl.push_back(mk(1, 5, 1, 5, 1, 9, 1, 0, 0,  0, 0, 0, 0)); // forwarded
      tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0,  0, 0, 0, 0)); // load r4
      tbl.push_back(mk(1, 4, 1, 0, 0,13, 1, 0, 1,  0, 1, 0, 0)); // mispredict
      tbl.push_back(mk(1, 4, 1, 0, 0,13, 1, 0, 0,  0, 0, 0, 0)); // r4 squashed
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0)); // load r0
      tbl.push_back(mk(1, 0, 1, 0, 1, 9, 1, 0, 0,  0, 0, 0, 0)); // read r0
      tbl.push_back(mk(1, 0, 0, 0, 0,10, 1, 1, 0,  0, 0, 0, 0)); // load r10
      tbl.push_back(mk(0,10, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // bubble
      tbl.push_back(mk(1,10, 1, 0, 0,12, 0, 0, 0,  1, 0, 0, 0));
      tbl.push_back(mk(1,10, 1, 0, 0,12, 0, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 0,  0, 0, 0, 0)); // load r2
      tbl.push_back(mk(1, 2, 1, 0, 0,12, 0, 0, 0,  1, 0, 0, 0));
      tbl.push_back(mk(1, 2, 1, 0, 0,12, 0, 0, 1,  0, 1, 1, 0)); // flush mid-stall
      tbl.push_back(mk(1, 2, 1, 0, 0,12, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0,11, 1, 1, 1,  0, 1, 0, 0)); // load during flush
      tbl.push_back(mk(1,11, 1, 0, 0,12, 0, 0, 0,  0, 0, 0, 0)); // never issued

      // Reset state, with a mispredict asserted to show flush is held low.
      br_mispredict = 1'b1;
      #3;
      chk("rst_stall", int'(stall), 0);
      chk("rst_flush", int'(flush), 0);
      chk("rst_run", int'(stall_run), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_overrun3", int'(overrun3), 0);
      br_mispredict = 1'b0;
      @(negedge clk) rst_n = 1'b1;

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         drive(tbl[i]);
         exp_q.push_back(tbl[i]);
      end
      @(posedge clk); #1 idle();
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);

      // Overrun with a three-cycle load against a two-deep replay queue.
      rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1 drive(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0));
      @(posedge clk); #1 drive(mk(1, 3, 1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0));
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("ovr_stall3", int'(stall3), (c < 3) ? 1 : 0);
         chk("ovr_run3", int'(stall_run3), c);
         chk("ovr_overrun3", int'(overrun3), (c == 3) ? 1 : 0);
         @(posedge clk); #1;
      end
      idle();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("ovr_sticky3", int'(overrun3), 1);
         chk("ovr_run3_clear", int'(stall_run3), 0);
         @(posedge clk); #1;
      end
      chk("ovr_default_clean", int'(overrun), 0);

      // Reset asserted during the second stall cycle.
      drive(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0));
      @(posedge clk); #1 drive(mk(1, 3, 1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk("mid_stall1", int'(stall), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_stall2", int'(stall), 1);
      chk("mid_run2", int'(stall_run), 1);
      #1 rst_n = 1'b0;
      br_mispredict = 1'b1;
      #1;
      chk("mid_rst_stall", int'(stall), 0);
      chk("mid_rst_flush", int'(flush), 0);
      @(posedge clk);
      @(negedge clk);
      br_mispredict = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("post_rst_run", int'(stall_run), 0);
      chk("post_rst_overrun", int'(overrun), 0);
      chk("post_rst_overrun3", int'(overrun3), 0);
      chk("post_rst_stall", int'(stall), 0);
      @(posedge clk); #1 idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
